// File: rtl/neuron_datapath_pkg.sv
// Shared widths, stage-0 pipeline record and fixed-point helpers for the MLP datapath.
package mlp_pkg;

   localparam int DATA_W  = 16;
   localparam int FRAC_W  = 8;
   localparam int ACC_W   = 2*DATA_W + 8;
   localparam int NADDR_W = 12;
   localparam int WADDR_W = 16;

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DATA_W-1) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   typedef struct packed {
      logic               valid;
      logic               flush;
      logic               last;
      logic               is_final;
      logic               hit;
      logic [NADDR_W-1:0] addr;
   } stage0_t;

   // Arithmetic shift floors toward minus infinity before clamping.
   function automatic logic signed [DATA_W-1:0] sat_shift(input logic signed [ACC_W-1:0] sum);
      logic signed [ACC_W-1:0] sh;
      sh = sum >>> FRAC_W;
      if (sh > SAT_MAX)
         sat_shift = SAT_MAX[DATA_W-1:0];
      else if (sh < SAT_MIN)
         sat_shift = SAT_MIN[DATA_W-1:0];
      else
         sat_shift = sh[DATA_W-1:0];
   endfunction

   function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
      relu = x[DATA_W-1] ? '0 : x;
   endfunction

endpackage

// File: rtl/neuron_datapath_mac_stage.sv
// Combinational multiply-accumulate with shift, saturation and activation.
module mac_stage
   import mlp_pkg::*;
(
   input  logic signed [ACC_W-1:0]  acc,
   input  logic signed [DATA_W-1:0] n,
   input  logic signed [DATA_W-1:0] w,
   input  logic                     is_final,
   output logic signed [ACC_W-1:0]  sum,
   output logic signed [DATA_W-1:0] r,
   output logic signed [DATA_W-1:0] act
);

   logic signed [2*DATA_W-1:0] prod;

   always_comb begin
      prod = n * w;
      sum  = acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
      r    = sat_shift(sum);
      act  = is_final ? r : relu(r);
   end

endmodule

// File: rtl/neuron_datapath.sv
// Two-stage neuron MAC pipeline: term registration, bypassed operand select,
// accumulation and write-back of activated neurons to external memory.
module neuron_datapath
   import mlp_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [NADDR_W-1:0] input_neuron_addr,
   input  logic [NADDR_W-1:0] output_neuron_addr,
   input  logic [WADDR_W-1:0] input_weight_addr,
   input  logic               write_neuron,
   input  logic               reset_mult_acc,
   input  logic               done,
   output logic [NADDR_W-1:0] neuron_rd_addr,
   output logic [WADDR_W-1:0] weight_rd_addr,
   input  logic [DATA_W-1:0]  neuron_rd_data,
   input  logic [DATA_W-1:0]  weight_rd_data,
   output logic               neuron_wr_en,
   output logic [NADDR_W-1:0] neuron_wr_addr,
   output logic [DATA_W-1:0]  neuron_wr_data,
   output logic [DATA_W-1:0]  mlp_result,
   output logic               mlp_done
);

   stage0_t                  s0_d;
   stage0_t                  s0_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  sum;
   logic signed [DATA_W-1:0] op_n;
   logic signed [DATA_W-1:0] r;
   logic signed [DATA_W-1:0] act;
   logic                     done_seen;
   logic                     flush;

   assign neuron_rd_addr = input_neuron_addr;
   assign weight_rd_addr = input_weight_addr;

   always_comb begin
      flush       = reset_mult_acc & ~write_neuron;
      s0_d        = '0;
      s0_d.flush  = flush;
      s0_d.valid  = ~flush & ~done_seen;
      s0_d.last   = write_neuron;
      s0_d.is_final = done;
      s0_d.addr   = output_neuron_addr;
      s0_d.hit    = neuron_wr_en && (neuron_wr_addr == input_neuron_addr);
   end

   // Memory returns pre-write data when read and write collide; forward the write value instead.
   assign op_n = s0_q.hit ? $signed(neuron_wr_data) : $signed(neuron_rd_data);

   mac_stage u_mac (
      .acc      (acc_q),
      .n        (op_n),
      .w        ($signed(weight_rd_data)),
      .is_final (s0_q.is_final),
      .sum      (sum),
      .r        (r),
      .act      (act)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s0_q           <= '0;
         acc_q          <= '0;
         done_seen      <= 1'b0;
         neuron_wr_en   <= 1'b0;
         neuron_wr_addr <= '0;
         neuron_wr_data <= '0;
         mlp_result     <= '0;
         mlp_done       <= 1'b0;
      end else begin
         s0_q         <= s0_d;
         neuron_wr_en <= 1'b0;
         if (s0_q.flush) begin
            acc_q     <= '0;
            done_seen <= 1'b0;
            mlp_done  <= 1'b0;
         end else if (s0_q.valid && !done_seen) begin
            // The term right after the final one was registered before done_seen rose; drop it here.
            if (s0_q.last) begin
               acc_q          <= '0;
               neuron_wr_en   <= 1'b1;
               neuron_wr_addr <= s0_q.addr;
               neuron_wr_data <= act;
               if (s0_q.is_final) begin
                  mlp_result <= r;
                  done_seen  <= 1'b1;
                  mlp_done   <= 1'b1;
               end
            end else begin
               acc_q <= sum;
            end
         end
      end
   end

endmodule

// File: tb/tb_neuron_datapath.sv
// Self-checking bench for neuron_datapath: directed vector table, hand sequences
// and randomized 4-2-2-1 networks checked against an integer reference model.
module tb_neuron_datapath;
   import mlp_pkg::*;

   typedef struct {
      logic [DATA_W-1:0] n;
      logic [DATA_W-1:0] w;
      int                terms;
      logic              fin;
      logic [DATA_W-1:0] exp_wr;
   } vec_t;

   typedef struct {
      logic [NADDR_W-1:0] a;
      logic [DATA_W-1:0]  d;
   } wr_t;

   logic               clk = 1'b0;
   logic               reset;
   logic [NADDR_W-1:0] input_neuron_addr, output_neuron_addr, neuron_rd_addr, neuron_wr_addr;
   logic [WADDR_W-1:0] input_weight_addr, weight_rd_addr;
   logic               write_neuron, reset_mult_acc, done, neuron_wr_en, mlp_done;
   logic [DATA_W-1:0]  neuron_rd_data, weight_rd_data, neuron_wr_data, mlp_result;

   logic [DATA_W-1:0]  nmem [0:4095];
   logic [DATA_W-1:0]  wmem [0:65535];
   logic               ld_en;
   logic [NADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0]  ld_data;
   wr_t                wlog[$];
   int                 checks = 0;
   int                 errors = 0;

   neuron_datapath dut (
      .clk                (clk),
      .reset              (reset),
      .input_neuron_addr  (input_neuron_addr),
      .output_neuron_addr (output_neuron_addr),
      .input_weight_addr  (input_weight_addr),
      .write_neuron       (write_neuron),
      .reset_mult_acc     (reset_mult_acc),
      .done               (done),
      .neuron_rd_addr     (neuron_rd_addr),
      .weight_rd_addr     (weight_rd_addr),
      .neuron_rd_data     (neuron_rd_data),
      .weight_rd_data     (weight_rd_data),
      .neuron_wr_en       (neuron_wr_en),
      .neuron_wr_addr     (neuron_wr_addr),
      .neuron_wr_data     (neuron_wr_data),
      .mlp_result         (mlp_result),
      .mlp_done           (mlp_done)
   );

   always #5 clk = ~clk;

   // Synchronous memories with read-before-write behaviour.
   always @(posedge clk) begin
      if (neuron_wr_en)
         nmem[neuron_wr_addr] <= neuron_wr_data;
      else if (ld_en)
         nmem[ld_addr] <= ld_data;
      neuron_rd_data <= nmem[neuron_rd_addr];
      weight_rd_data <= wmem[weight_rd_addr];
   end

   always @(negedge clk)
      if (neuron_wr_en)
         wlog.push_back('{neuron_wr_addr, neuron_wr_data});

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic [NADDR_W-1:0] na, input logic [WADDR_W-1:0] wa,
                       input logic [NADDR_W-1:0] oa, input logic wn, input logic rma,
                       input logic dn);
      input_neuron_addr  = na;
      input_weight_addr  = wa;
      output_neuron_addr = oa;
      write_neuron       = wn;
      reset_mult_acc     = rma;
      done               = dn;
      @(posedge clk);
      #1;
   endtask

   task automatic flush_cyc();
      step(12'hFFF, 16'hFFFF, 12'h000, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic load_n(input logic [NADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      flush_cyc();
      ld_en   = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_wr_en"},   64'(neuron_wr_en),   64'd0);
      check({tag, "_wr_addr"}, 64'(neuron_wr_addr), 64'd0);
      check({tag, "_wr_data"}, 64'(neuron_wr_data), 64'd0);
      check({tag, "_result"},  64'(mlp_result),     64'd0);
      check({tag, "_done"},    64'(mlp_done),       64'd0);
   endtask

   function automatic longint rnd(input bit full);
      if (full)
         return longint'($signed(16'($urandom)));
      return longint'($urandom_range(0, 2047)) - 64'sd1024;
   endfunction

   task automatic run_net(input bit full);
      int     sizes[4] = '{4, 2, 2, 1};
      int     bases[4] = '{0, 4, 6, 8};
      longint vals[9];
      longint sum, r, wv;
      int     wa, base, nw;
      for (int i = 0; i < 4; i++) begin
         vals[i] = rnd(full);
         load_n(12'(i), vals[i][15:0]);
      end
      for (int a = 4; a < 9; a++)
         load_n(12'(a), 16'h5A5A);
      wa = 'h1000;
      for (int l = 1; l < 4; l++)
         for (int j = 0; j < sizes[l]; j++) begin
            sum = 0;
            for (int i = 0; i < sizes[l-1]; i++) begin
               wv = rnd(full);
               wmem[16'(wa)] = wv[15:0];
               wa++;
               sum += vals[bases[l-1] + i] * wv;
            end
            r = sum >>> FRAC_W;
            if (r > 32767) r = 32767;
            else if (r < -32768) r = -32768;
            if (l < 3 && r < 0) r = 0;
            vals[bases[l] + j] = r;
         end
      flush_cyc();
      base = wlog.size();
      // Second pass mimics the controller cycling its pointers after done.
      for (int pass = 0; pass < 2; pass++) begin
         wa = 'h1000;
         for (int l = 1; l < 4; l++)
            for (int j = 0; j < sizes[l]; j++)
               for (int i = 0; i < sizes[l-1]; i++) begin
                  logic last;
                  last = (i == sizes[l-1] - 1);
                  step(12'(bases[l-1] + i), 16'(wa), 12'(bases[l] + j), last, last,
                       last && (l == 3));
                  wa++;
               end
      end
      nw = wlog.size() - base;
      check("net_wr_count", 64'(nw), 64'd5);
      for (int k = 0; k < 5 && k < nw; k++) begin
         check("net_wr_addr", 64'(wlog[base+k].a), 64'(4 + k));
         check("net_wr_data", 64'(wlog[base+k].d), 64'(vals[4+k][15:0]));
      end
      check("net_mlp_result", 64'(mlp_result), 64'(vals[8][15:0]));
      check("net_mlp_done",   64'(mlp_done),   64'd1);
      flush_cyc();
      flush_cyc();
      check("net_flush_done", 64'(mlp_done), 64'd0);
   endtask

   vec_t vt[8];

   initial begin
      vt[0] = '{16'h0100, 16'h0180, 1, 1'b0, 16'h0180};
      vt[1] = '{16'h0100, 16'h0200, 4, 1'b0, 16'h0800};
      vt[2] = '{16'h0100, 16'hFE00, 1, 1'b0, 16'h0000};
      vt[3] = '{16'h0100, 16'hFE00, 1, 1'b1, 16'hFE00};
      vt[4] = '{16'h7FFF, 16'h7FFF, 4, 1'b0, 16'h7FFF};
      vt[5] = '{16'h7FFF, 16'h8001, 4, 1'b1, 16'h8000};
      vt[6] = '{16'hFFFF, 16'h0001, 1, 1'b1, 16'hFFFF};
      vt[7] = '{16'h0080, 16'h0080, 1, 1'b0, 16'h0040};

      reset              = 1'b0;
      ld_en              = 1'b0;
      ld_addr            = '0;
      ld_data            = '0;
      input_neuron_addr  = 12'hABC;
      input_weight_addr  = 16'h1234;
      output_neuron_addr = '0;
      write_neuron       = 1'b0;
      reset_mult_acc     = 1'b1;
      done               = 1'b0;
      #3;
      check_outputs_zero("rst");
      check("rd_addr_pass", 64'(neuron_rd_addr), 64'h0ABC);
      check("wa_addr_pass", 64'(weight_rd_addr), 64'h1234);
      @(negedge clk);
      reset = 1'b1;
      flush_cyc();
      flush_cyc();

      for (int k = 0; k < 8; k++) begin
         for (int t = 0; t < vt[k].terms; t++)
            wmem[16'(200 + t)] = vt[k].w;
         load_n(12'd100, vt[k].n);
         flush_cyc();
         for (int t = 0; t < vt[k].terms; t++) begin
            logic last;
            last = (t == vt[k].terms - 1);
            step(12'd100, 16'(200 + t), 12'(300 + k), last, last, last && vt[k].fin);
         end
         check("vec_wr_en_t1", 64'(neuron_wr_en), 64'd0);
         flush_cyc();
         check("vec_wr_en_t2", 64'(neuron_wr_en),   64'd1);
         check("vec_wr_addr",  64'(neuron_wr_addr), 64'(300 + k));
         check("vec_wr_data",  64'(neuron_wr_data), 64'(vt[k].exp_wr));
         check("vec_mlp_done", 64'(mlp_done),       64'(vt[k].fin));
         if (vt[k].fin)
            check("vec_mlp_result", 64'(mlp_result), 64'(vt[k].exp_wr));
         flush_cyc();
         check("vec_wr_en_t3", 64'(neuron_wr_en), 64'd0);
         check("vec_done_flush", 64'(mlp_done), 64'd0);
      end

      // Back-to-back neurons: second must start from a cleared accumulator.
      for (int t = 0; t < 4; t++)
         wmem[16'(400 + t)] = 16'h0200;
      wmem[404] = 16'h0100;
      load_n(12'd101, 16'h0100);
      flush_cyc();
      for (int t = 0; t < 4; t++)
         step(12'd101, 16'(400 + t), 12'd310, t == 3, t == 3, 1'b0);
      step(12'd101, 16'd404, 12'd311, 1'b1, 1'b1, 1'b0);
      check("b2b_a_en",   64'(neuron_wr_en),   64'd1);
      check("b2b_a_addr", 64'(neuron_wr_addr), 64'd310);
      check("b2b_a_data", 64'(neuron_wr_data), 64'h0800);
      flush_cyc();
      check("b2b_b_en",   64'(neuron_wr_en),   64'd1);
      check("b2b_b_addr", 64'(neuron_wr_addr), 64'd311);
      check("b2b_b_data", 64'(neuron_wr_data), 64'h0100);
      flush_cyc();

      for (int run = 0; run < 6; run++)
         run_net(run == 5);

      // Asynchronous reset in the middle of a neuron.
      wmem[500] = 16'h0300;
      wmem[501] = 16'h0300;
      wmem[502] = 16'h0180;
      load_n(12'd110, 16'h0100);
      flush_cyc();
      step(12'd110, 16'd500, 12'd320, 1'b0, 1'b0, 1'b0);
      step(12'd110, 16'd501, 12'd320, 1'b0, 1'b0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check_outputs_zero("midrst");
      #1;
      reset = 1'b1;
      step(12'd110, 16'd502, 12'd321, 1'b1, 1'b1, 1'b0);
      flush_cyc();
      check("postrst_en",   64'(neuron_wr_en),   64'd1);
      check("postrst_addr", 64'(neuron_wr_addr), 64'd321);
      check("postrst_data", 64'(neuron_wr_data), 64'h0180);
      flush_cyc();
      run_net(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/neuron_datapath.md
# neuron_datapath

Multiply-accumulate datapath directly downstream of `control_unit`. It consumes the per-cycle neuron and weight addresses plus the `write_neuron`, `reset_mult_acc` and `done` strobes. For each term it reads one neuron and one weight from external synchronous memories and accumulates the signed fixed-point product. On the last term of a neuron it writes the activated result back to neuron memory. On the final neuron it presents the network output and raises `mlp_done`.

## Interface
- `DATA_W`, 16: neuron and weight width, signed two's complement.
- `FRAC_W`, 8: fractional bits. 1.0 = 0x0100.
- `ACC_W`, 40: accumulator width, equal to 2*DATA_W+8.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `input_neuron_addr`  in  12  neuron read address from `control_unit`.
- `output_neuron_addr`  in  12  write-back address for the neuron being computed.
- `input_weight_addr`  in  16  weight read address.
- `write_neuron`  in  1  current term is the last term of its neuron.
- `reset_mult_acc`  in  1  accumulator clear strobe from `control_unit`.
- `done`  in  1  current last term belongs to the final neuron.
- `neuron_rd_addr`  out  12  combinational copy of `input_neuron_addr`.
- `weight_rd_addr`  out  16  combinational copy of `input_weight_addr`.
- `neuron_rd_data`  in  DATA_W  neuron memory read data; 1-cycle synchronous read latency.
- `weight_rd_data`  in  DATA_W  weight memory read data; 1-cycle synchronous read latency.
- `neuron_wr_en`  out  1  single-cycle write strobe.
- `neuron_wr_addr`  out  12  write address.
- `neuron_wr_data`  out  DATA_W  write data.
- `mlp_result`  out  DATA_W  final output neuron value, before activation.
- `mlp_done`  out  1  sticky indication that `mlp_result` is valid.

## Operation
- Term classification, evaluated at cycle T:
  - Flush when `reset_mult_acc`=1 and `write_neuron`=0.
  - Valid term when not flush and `done_seen`=0.
  - Otherwise idle.
- Stage 0 (cycle T):
  - Addresses pass combinationally to the memories.
  - Register `valid`, `last`=`write_neuron`, `final`=`done`, `output_neuron_addr`, and the bypass flag.
- Stage 1 (cycle T+1):
  - Operand n = bypass hit ? `neuron_wr_data` : `neuron_rd_data`; w = `weight_rd_data`.
  - prod = n*w, full 2*DATA_W signed; sum = acc + sign-extended prod.
  - Valid and not last: acc <= sum.
  - Valid and last:
    - r = sat_DATA_W(sum >>> FRAC_W), arithmetic shift (floor).
    - Write registers <= (addr, final ? r : max(r,0)); wr_en <= 1; acc <= 0.
  - Valid and last and final: additionally `mlp_result` <= r and `done_seen` <= 1.
  - Flush: acc <= 0, `done_seen` <= 0, `mlp_done` <= 0.
- Saturation: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Bypass (read-after-write across the layer boundary):
  - Hazard: `neuron_wr_en`=1 and `neuron_wr_addr`=`neuron_rd_addr` in the same cycle.
  - Latch a hit flag; the next cycle uses the written value instead of memory data.
  - Hidden layers have at least 2 neurons (`control_unit` treats a count of 1 as final), so a 1-deep bypass covers every hazard.
- After `done_seen`, ignore all terms. `control_unit` keeps cycling its pointers; this block issues no further writes.
- Reset (asynchronous, low):
  - acc, all pipeline registers, `neuron_wr_en`, `neuron_wr_addr`, `neuron_wr_data`, `mlp_result`, `mlp_done`, `done_seen` and the bypass flag all go to 0.
  - A reset mid-neuron discards the partial sum.

## Timing
- Last-term addresses at cycle T → `neuron_wr_en` high for exactly cycle T+2.
- Final last term at cycle T → `mlp_done` rises at cycle T+2.
- One term accepted per cycle, no stalls, no backpressure.
- Accumulator clear takes effect at the edge ending cycle T+1, so the next neuron's first term (addresses at T+1) starts from 0.
- A flush takes effect at the edge ending the cycle in which it is seen at stage 1.

## Structure
- Package `mlp_pkg` holds:
  - `DATA_W`, `FRAC_W`, `ACC_W`, `NADDR_W`=12, `WADDR_W`=16;
  - function `sat_shift(sum)` (shift plus saturate);
  - function `relu`.
- One sub-module `mac_stage`: combinational product, sum, shift, saturate and activate, shared with future layer variants.
- Top level holds the stage-0 registers, the bypass logic and the write/done registers.

## Test plan
- Single term, n=0x0100, w=0x0180, last=1 → at T+2 wr_en=1, wr_data=0x0180.
- Four terms of 0x0100 × 0x0200 with the last flagged → wr_data=0x0800; the next neuron's accumulation starts from 0.
- Negative sum, n=0x0100, w=0xFE00, hidden layer → wr_data=0x0000 (ReLU). Same term with done=1 → mlp_result=0xFE00 and mlp_done=1.
- Overflow, 4 × (0x7FFF × 0x7FFF) → wr_data=0x7FFF. Negative case → 0x8000 on the final neuron.
- Full 4-2-2-1 schedule driven by a `control_unit` model:
  - the layer-2 read of neuron 1 coincides with its write, and the bypass supplies the fresh value;
  - mlp_result matches the golden model;
  - no writes occur after done.
- Assert reset low mid-neuron → all outputs 0 immediately. After release, a fresh run yields the correct result. A flush from `control_unit` clears `mlp_done`.
